// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
//   Requester-side bus of the shared-memory arbiter: one instruction-fetch
//   port (read only) and one data port (load/store).
//
//   Instruction port : iReq, iAddr         -> iGnt, iRvalid, iRdata
//   Data port        : dReq, dWe, dAddr, dWdata -> dGnt, dRvalid, dRdata
//
//   modport master : the requesters (drive req/address/data, see responses)
//   modport slave  : the arbiter (sees requests, drives grants/responses)
// ---------------------------------------------------------------------------
interface mem_arbiter_if;
    logic        iReq;
    logic [31:0] iAddr;
    logic        iGnt;
    logic        iRvalid;
    logic [31:0] iRdata;

    logic        dReq;
    logic        dWe;
    logic [31:0] dAddr;
    logic [31:0] dWdata;
    logic        dGnt;
    logic        dRvalid;
    logic [31:0] dRdata;

    modport master (
        output iReq, iAddr,
        input  iGnt, iRvalid, iRdata,
        output dReq, dWe, dAddr, dWdata,
        input  dGnt, dRvalid, dRdata
    );

    modport slave (
        input  iReq, iAddr,
        output iGnt, iRvalid, iRdata,
        input  dReq, dWe, dAddr, dWdata,
        output dGnt, dRvalid, dRdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Arbitrates an instruction-fetch port and a data port onto one shared
//   32-bit memory with combinational read and posedge-Clk write. Each
//   transaction takes IDLE -> ACCESS -> RESP (one per three cycles):
//   the winner is latched on leaving IDLE, its gnt is high during ACCESS
//   (where the memory is driven), its rvalid/err are high during RESP.
//
//   Build option: define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration
//   on conflicts; otherwise the data port always wins conflicts.
//
// Ports
//   Clk            clock, all state changes on its rising edge
//   Rst_n          asynchronous active-low reset
//   bus            requester bus (mem_arbiter_if.slave)
//   err            high in RESP when the served address was out of range
//   busy           high whenever the arbiter is not idle
//   memAddress     word address to memory (0 outside ACCESS)
//   memWriteData   write data to memory (0 outside ACCESS)
//   memWriteEnable write strobe to memory (ACCESS, store, in range only)
//   memData        combinational read data from memory
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int MEM_DEPTH = 1024
) (
    input  logic          Clk,
    input  logic          Rst_n,
    mem_arbiter_if.slave  bus,
    output logic          err,
    output logic          busy,
    output logic [31:0]   memAddress,
    output logic [31:0]   memWriteData,
    output logic          memWriteEnable,
    input  logic [31:0]   memData
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state, next_state;

    // Transaction latched on the IDLE->ACCESS edge.
    logic        sel_d;      // 1 = data port won, 0 = instruction port won
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;

    logic [31:0] irdata_q;
    logic [31:0] drdata_q;

    logic        any_req;
    logic        prefer_d;
    logic        pick_d;
    logic        in_range;
    logic [31:0] rdata_next;

    assign any_req  = bus.iReq | bus.dReq;
    assign in_range = addr_q < 32'(MEM_DEPTH);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Remembers which port was granted last; starts as "instruction" so the
    // data port wins the first conflict after reset.
    logic last_i;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            last_i <= 1'b1;
        end else if (state == IDLE && any_req) begin
            last_i <= ~pick_d;
        end
    end

    assign prefer_d = last_i;
`else
    assign prefer_d = 1'b1;
`endif

    // A lone request always wins; prefer_d only matters on a conflict.
    assign pick_d = bus.dReq & (~bus.iReq | prefer_d);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        next_state     = state;
        bus.iGnt       = 1'b0;
        bus.dGnt       = 1'b0;
        bus.iRvalid    = 1'b0;
        bus.dRvalid    = 1'b0;
        err            = 1'b0;
        busy           = 1'b1;
        memAddress     = 32'd0;
        memWriteData   = 32'd0;
        memWriteEnable = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (any_req) next_state = ACCESS;
            end
            ACCESS: begin
                next_state   = RESP;
                bus.iGnt     = ~sel_d;
                bus.dGnt     = sel_d;
                memAddress   = addr_q;
                memWriteData = wdata_q;
                // NOTE: the write strobe is decoded from state, not stored in
                // a flop, so an asynchronous reset in ACCESS drops it at once
                // and the memory cannot write on the following edge.
                memWriteEnable = we_q & in_range;
            end
            RESP: begin
                next_state  = IDLE;
                bus.iRvalid = ~sel_d;
                bus.dRvalid = sel_d;
                err         = ~in_range;
            end
            default: begin
                next_state = IDLE;
                busy       = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sel_d   <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
        end else if (state == IDLE && any_req) begin
            sel_d   <= pick_d;
            addr_q  <= pick_d ? bus.dAddr : bus.iAddr;
            wdata_q <= pick_d ? bus.dWdata : 32'd0;
            we_q    <= pick_d & bus.dWe;
        end
    end

    // Stores and out-of-range accesses return zero instead of memory data.
    assign rdata_next = (!we_q && in_range) ? memData : 32'd0;

    // Each port's read data holds until that port's next response.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            irdata_q <= 32'd0;
            drdata_q <= 32'd0;
        end else if (state == ACCESS) begin
            if (sel_d) drdata_q <= rdata_next;
            else       irdata_q <= rdata_next;
        end
    end

    assign bus.iRdata = irdata_q;
    assign bus.dRdata = drdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter. Provides the shared memory,
//   a transaction-level reference model (timeline of accepted transactions
//   plus a reference copy of memory), one per-cycle compare process, a few
//   hand-computed directed scenarios and a randomized requester phase.
//   Build with MEM_ARB_ROUND_ROBIN_EN defined to check the round-robin build.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int DEPTH = 1024;

    logic        Clk;
    logic        Rst_n;
    logic        err;
    logic        busy;
    logic [31:0] memAddress;
    logic [31:0] memWriteData;
    logic        memWriteEnable;
    logic [31:0] memData;

    mem_arbiter_if bus();

    mem_arbiter #(.MEM_DEPTH(DEPTH)) dut (
        .Clk            (Clk),
        .Rst_n          (Rst_n),
        .bus            (bus.slave),
        .err            (err),
        .busy           (busy),
        .memAddress     (memAddress),
        .memWriteData   (memWriteData),
        .memWriteEnable (memWriteEnable),
        .memData        (memData)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // ---------------- shared memory seen by the DUT ----------------
    logic [31:0] tb_mem [DEPTH];

    always @(posedge Clk) begin
        if (memWriteEnable === 1'b1 && memAddress < DEPTH)
            tb_mem[memAddress[9:0]] <= memWriteData;
    end

    // Out-of-range reads return a non-zero pattern so a missing zeroing shows.
    assign memData = (memAddress < DEPTH) ? tb_mem[memAddress[9:0]] : 32'hBAD0_0BAD;

    // ---------------- scoreboard counters ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Timeline view: a transaction accepted at edge k owns cycle k (grant,
    // memory access) and cycle k+1 (response); cycle k+2 is idle and the
    // next acceptance can happen at edge k+3 at the earliest.
    logic [31:0] ref_mem [DEPTH];
    int          edge_no   = 0;
    int          acc_edge  = -100;
    bit          tx_d      = 1'b0;
    bit          tx_we     = 1'b0;
    bit          tx_ok     = 1'b0;
    logic [31:0] tx_addr   = '0;
    logic [31:0] tx_wdata  = '0;
    logic [31:0] tx_res    = '0;
    logic [31:0] exp_irdata = '0;
    logic [31:0] exp_drdata = '0;
    bit          last_i    = 1'b1;

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            acc_edge   = -100;
            exp_irdata = '0;
            exp_drdata = '0;
            last_i     = 1'b1;
        end else begin
            bit d_wins;
            edge_no++;
            // Response edge of the transaction in flight: commit its effects.
            if (edge_no == acc_edge + 1) begin
                if (tx_we && tx_ok) ref_mem[tx_addr[9:0]] = tx_wdata;
                if (tx_d) exp_drdata = tx_res;
                else      exp_irdata = tx_res;
            end
            if (edge_no >= acc_edge + 3 && (bus.iReq || bus.dReq)) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                d_wins = bus.dReq && (!bus.iReq || last_i);
`else
                d_wins = bus.dReq;
`endif
                last_i   = !d_wins;
                acc_edge = edge_no;
                tx_d     = d_wins;
                tx_addr  = d_wins ? bus.dAddr : bus.iAddr;
                tx_we    = d_wins && bus.dWe;
                tx_wdata = d_wins ? bus.dWdata : 32'd0;
                tx_ok    = tx_addr < DEPTH;
                tx_res   = (!tx_we && tx_ok) ? ref_mem[tx_addr[9:0]] : 32'd0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge Clk) begin
        if (Rst_n === 1'b1) begin
            bit in_acc, in_resp;
            in_acc  = (edge_no == acc_edge);
            in_resp = (edge_no == acc_edge + 1);
            check("iGnt",    32'(bus.iGnt),    32'(in_acc && !tx_d));
            check("dGnt",    32'(bus.dGnt),    32'(in_acc && tx_d));
            check("iRvalid", 32'(bus.iRvalid), 32'(in_resp && !tx_d));
            check("dRvalid", 32'(bus.dRvalid), 32'(in_resp && tx_d));
            check("err",     32'(err),         32'(in_resp && !tx_ok));
            check("busy",    32'(busy),        32'(in_acc || in_resp));
            check("iRdata",  bus.iRdata,       exp_irdata);
            check("dRdata",  bus.dRdata,       exp_drdata);
            check("memAddress",     memAddress,   in_acc ? tx_addr : 32'd0);
            check("memWriteData",   memWriteData, in_acc ? tx_wdata : 32'd0);
            check("memWriteEnable", 32'(memWriteEnable), 32'(in_acc && tx_we && tx_ok));
        end
    end

    // ---------------- directed transaction helper ----------------
    int          lat;
    logic        cap_we;
    logic [31:0] cap_addr;
    logic [31:0] cap_wd;
    logic        cap_rv;
    logic        cap_err;
    logic [31:0] cap_rd;

    // Called while the arbiter is idle; returns in the idle cycle after RESP.
    task automatic tx(input bit is_d, input bit we, input logic [31:0] a, input logic [31:0] wd);
        if (is_d) begin
            bus.dReq = 1'b1; bus.dWe = we; bus.dAddr = a; bus.dWdata = wd;
        end else begin
            bus.iReq = 1'b1; bus.iAddr = a;
        end
        lat = 0;
        do begin
            @(posedge Clk); #1;
            lat++;
        end while ((is_d ? bus.dGnt : bus.iGnt) !== 1'b1 && lat < 8);
        cap_we   = memWriteEnable;
        cap_addr = memAddress;
        cap_wd   = memWriteData;
        bus.iReq = 1'b0;
        bus.dReq = 1'b0;
        bus.dWe  = 1'b0;
        @(posedge Clk); #1;
        cap_rv  = is_d ? bus.dRvalid : bus.iRvalid;
        cap_err = err;
        cap_rd  = is_d ? bus.dRdata : bus.iRdata;
        @(posedge Clk); #1;
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 32'(DEPTH) + 32'($urandom_range(0, 3));
        if (r == 1) return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        if (r == 2) return 32'(DEPTH - 1);
        return 32'($urandom_range(0, 15));
    endfunction

    task automatic run_random(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge Clk); #1;
            if ($urandom_range(0, 299) == 0) begin
                Rst_n = 1'b0;
                bus.iReq = 1'b0;
                bus.dReq = 1'b0;
                @(negedge Clk); #1;
                Rst_n = 1'b1;
                continue;
            end
            if (bus.iReq && bus.iGnt === 1'b1) begin
                if ($urandom_range(0, 1) == 1) bus.iAddr = rand_addr();
                else                           bus.iReq  = 1'b0;
            end else if (!bus.iReq && $urandom_range(0, 9) < 4) begin
                bus.iReq  = 1'b1;
                bus.iAddr = rand_addr();
            end
            if (bus.dReq && bus.dGnt === 1'b1) begin
                if ($urandom_range(0, 1) == 1) begin
                    bus.dAddr  = rand_addr();
                    bus.dWe    = 1'($urandom_range(0, 1));
                    bus.dWdata = $urandom;
                end else begin
                    bus.dReq = 1'b0;
                end
            end else if (!bus.dReq && $urandom_range(0, 9) < 4) begin
                bus.dReq   = 1'b1;
                bus.dAddr  = rand_addr();
                bus.dWe    = 1'($urandom_range(0, 1));
                bus.dWdata = $urandom;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [3:0]  order;
        logic [3:0]  exp_order;
        int          n_gnt;
        int          guard;

        Rst_n = 1'b0;
        bus.iReq = 1'b0; bus.iAddr = '0;
        bus.dReq = 1'b0; bus.dWe = 1'b0; bus.dAddr = '0; bus.dWdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            tb_mem[i]  = {16'hC0DE, 16'(i)};
            ref_mem[i] = {16'hC0DE, 16'(i)};
        end
        tb_mem[128]  = 32'h0022_1820;
        ref_mem[128] = 32'h0022_1820;

        // Reset state.
        repeat (2) @(posedge Clk);
        #1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst gnt", {30'd0, bus.iGnt, bus.dGnt}, 32'd0);
        check("rst rvalid", {30'd0, bus.iRvalid, bus.dRvalid}, 32'd0);
        check("rst mwe", 32'(memWriteEnable), 32'd0);
        check("rst iRdata", bus.iRdata, 32'd0);
        check("rst dRdata", bus.dRdata, 32'd0);
        @(negedge Clk); #1;
        Rst_n = 1'b1;

        // Store 0x55 to address 5, accepted at the first edge after reset.
        tx(1'b1, 1'b1, 32'd5, 32'h55);
        check("st5 latency", 32'(lat), 32'd1);
        check("st5 mwe", 32'(cap_we), 32'd1);
        check("st5 addr", cap_addr, 32'd5);
        check("st5 wdata", cap_wd, 32'h55);
        check("st5 rvalid", 32'(cap_rv), 32'd1);
        check("st5 err", 32'(cap_err), 32'd0);
        check("st5 rdata", cap_rd, 32'd0);

        // Load back from address 5.
        tx(1'b1, 1'b0, 32'd5, 32'd0);
        check("ld5 latency", 32'(lat), 32'd1);
        check("ld5 mwe", 32'(cap_we), 32'd0);
        check("ld5 rdata", cap_rd, 32'h55);

        // Instruction fetch from 128.
        tx(1'b0, 1'b0, 32'd128, 32'd0);
        check("if128 latency", 32'(lat), 32'd1);
        check("if128 rvalid", 32'(cap_rv), 32'd1);
        check("if128 err", 32'(cap_err), 32'd0);
        check("if128 rdata", cap_rd, 32'h0022_1820);

        // Last valid address and first invalid address.
        tx(1'b0, 1'b0, 32'd1023, 32'd0);
        check("if1023 rdata", cap_rd, 32'hC0DE_03FF);
        check("if1023 err", 32'(cap_err), 32'd0);
        tx(1'b1, 1'b1, 32'd1024, 32'hFFFF_FFFF);
        check("st1024 mwe", 32'(cap_we), 32'd0);
        check("st1024 rvalid", 32'(cap_rv), 32'd1);
        check("st1024 err", 32'(cap_err), 32'd1);
        check("st1024 rdata", cap_rd, 32'd0);
        check("mem1023 intact", tb_mem[1023], 32'hC0DE_03FF);

        // Conflict: both ports held high for four grants, from fresh reset.
        Rst_n = 1'b0;
        #3;
        @(negedge Clk); #1;
        Rst_n = 1'b1;
        bus.iReq = 1'b1; bus.iAddr = 32'd1;
        bus.dReq = 1'b1; bus.dWe = 1'b0; bus.dAddr = 32'd2;
        order = '0;
        n_gnt = 0;
        guard = 0;
        while (n_gnt < 4 && guard < 40) begin
            @(posedge Clk); #1;
            guard++;
            if (bus.dGnt === 1'b1 || bus.iGnt === 1'b1) begin
                order = {order[2:0], bus.dGnt === 1'b1};
                n_gnt++;
            end
        end
        bus.iReq = 1'b0;
        bus.dReq = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_order = 4'b1010;
`else
        exp_order = 4'b1111;
`endif
        check("conflict grants", 32'(n_gnt), 32'd4);
        check("conflict order", 32'(order), 32'(exp_order));
        repeat (4) @(posedge Clk);
        #1;

        // Reset asserted during ACCESS of a store to address 7.
        bus.dReq = 1'b1; bus.dWe = 1'b1; bus.dAddr = 32'd7; bus.dWdata = 32'hDEAD_BEEF;
        @(posedge Clk); #1;
        check("st7 gnt", 32'(bus.dGnt), 32'd1);
        #2;
        Rst_n = 1'b0;
        bus.dReq = 1'b0; bus.dWe = 1'b0;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort gnt", {30'd0, bus.iGnt, bus.dGnt}, 32'd0);
        check("abort mwe", 32'(memWriteEnable), 32'd0);
        check("abort addr", memAddress, 32'd0);
        check("abort dRdata", bus.dRdata, 32'd0);
        check("abort iRdata", bus.iRdata, 32'd0);
        @(posedge Clk); #1;
        check("mem7 intact", tb_mem[7], 32'hC0DE_0007);
        @(negedge Clk); #1;
        Rst_n = 1'b1;
        tx(1'b1, 1'b0, 32'd7, 32'd0);
        check("ld7 latency", 32'(lat), 32'd1);
        check("ld7 rdata", cap_rd, 32'hC0DE_0007);

        // Randomized traffic checked cycle by cycle against the model.
        run_random(3000);
        bus.iReq = 1'b0;
        bus.dReq = 1'b0;
        repeat (4) @(posedge Clk);
        @(negedge Clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
